// File: rtl/seg7_serial_driver.sv
// Serialises the 64-bit active-low segment pattern onto the display shift-register chain.
// Every output is registered, so the board pins never see combinational glitches.
module seg7_serial_driver #(
   parameter int CLK_DIV = 2,
   parameter int WIDTH   = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pattern,
   input  logic             refresh,
   output logic             busy,
   output logic             done,
   output logic             seg_clk,
   output logic             seg_dout,
   output logic             seg_latch,
   output logic             seg_clrn
);

   localparam int DW = $clog2(CLK_DIV) + 1;
   localparam int BW = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sreg, sreg_nxt;
   logic [BW-1:0]    bitcnt, bitcnt_nxt;
   logic [DW-1:0]    divcnt, divcnt_nxt;
   logic             pending, pending_nxt;
   logic             phase_end;
   logic             busy_nxt, done_nxt, seg_clk_nxt, seg_dout_nxt, seg_latch_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sreg      <= '0;
         bitcnt    <= '0;
         divcnt    <= '0;
         pending   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         seg_clk   <= 1'b0;
         seg_dout  <= 1'b0;
         seg_latch <= 1'b0;
         seg_clrn  <= 1'b0;
      end else begin
         state     <= state_nxt;
         sreg      <= sreg_nxt;
         bitcnt    <= bitcnt_nxt;
         divcnt    <= divcnt_nxt;
         pending   <= pending_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         seg_clk   <= seg_clk_nxt;
         seg_dout  <= seg_dout_nxt;
         seg_latch <= seg_latch_nxt;
         seg_clrn  <= 1'b1;
      end
   end

   assign phase_end = (divcnt == DW'(CLK_DIV - 1));

   // NOTE: every variable gets a default at the top so no latch is inferred on untaken paths.
   always_comb begin
      state_nxt   = state;
      sreg_nxt    = sreg;
      bitcnt_nxt  = bitcnt;
      divcnt_nxt  = divcnt;
      pending_nxt = pending | (refresh && (state != IDLE));
      case (state)
         IDLE: begin
            if (refresh || pending) begin
               sreg_nxt    = pattern;
               bitcnt_nxt  = BW'(WIDTH - 1);
               divcnt_nxt  = '0;
               pending_nxt = 1'b0;
               state_nxt   = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (phase_end) begin
               divcnt_nxt = '0;
               state_nxt  = SHIFT_HI;
            end else begin
               divcnt_nxt = divcnt + DW'(1);
            end
         end
         SHIFT_HI: begin
            if (phase_end) begin
               divcnt_nxt = '0;
               sreg_nxt   = sreg << 1;
               if (bitcnt == '0) begin
                  state_nxt = LATCH;
               end else begin
                  bitcnt_nxt = bitcnt - BW'(1);
                  state_nxt  = SHIFT_LO;
               end
            end else begin
               divcnt_nxt = divcnt + DW'(1);
            end
         end
         LATCH: begin
            if (phase_end) begin
               divcnt_nxt = '0;
               state_nxt  = DONE;
            end else begin
               divcnt_nxt = divcnt + DW'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered alongside it.
   always_comb begin
      busy_nxt      = state_nxt inside {SHIFT_LO, SHIFT_HI, LATCH};
      done_nxt      = (state_nxt == DONE);
      seg_clk_nxt   = (state_nxt == SHIFT_HI);
      seg_latch_nxt = (state_nxt == LATCH);
      seg_dout_nxt  = 1'b0;
      if (state_nxt inside {SHIFT_LO, SHIFT_HI}) begin
         seg_dout_nxt = sreg_nxt[WIDTH-1];
      end
   end

endmodule

// File: tb/tb_seg7_serial_driver.sv
// Directed bench for seg7_serial_driver: one CLK_DIV=2 instance and one CLK_DIV=1 instance.
module tb_seg7_serial_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        refresh0 = 1'b0;
   logic        refresh1 = 1'b0;
   logic [63:0] pattern = '0;

   logic busy0, done0, seg_clk0, seg_dout0, seg_latch0, seg_clrn0;
   logic busy1, done1, seg_clk1, seg_dout1, seg_latch1, seg_clrn1;

   int passes = 0;
   int total  = 0;
   int cyc    = 0;

   logic [63:0] bits;
   int nb, busy_c, latch_c, latch_early, toggles, done_at, done_prev, acc;
   logic prev_clk;

   seg7_serial_driver #(.CLK_DIV(2), .WIDTH(64)) dut0 (
      .clk(clk), .rst_n(rst_n), .pattern(pattern), .refresh(refresh0),
      .busy(busy0), .done(done0), .seg_clk(seg_clk0), .seg_dout(seg_dout0),
      .seg_latch(seg_latch0), .seg_clrn(seg_clrn0)
   );

   seg7_serial_driver #(.CLK_DIV(1), .WIDTH(64)) dut1 (
      .clk(clk), .rst_n(rst_n), .pattern(pattern), .refresh(refresh1),
      .busy(busy1), .done(done1), .seg_clk(seg_clk1), .seg_dout(seg_dout1),
      .seg_latch(seg_latch1), .seg_clrn(seg_clrn1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // mode 0: single start pulse, 1: start pulse plus three queued pulses,
   // 2: refresh left as the caller set it, 3: transfer already queued.
   task automatic xfer(input bit sel, input bit scramble, input int mode,
                       output logic [63:0] b, output int n, output int bc, output int lc,
                       output int le, output int tg, output int da);
      logic pc, sc, sd, bz, lt, dn;
      pc = 1'b0; b = '0; n = 0; bc = 0; lc = 0; le = 0; tg = 0; da = -1;
      if (mode == 0 || mode == 1) refresh0 = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (mode == 0) refresh0 = 1'b0;
         if (mode == 1) refresh0 = (i == 10 || i == 50 || i == 100);
         if (scramble) pattern = {$urandom, $urandom};
         sc = sel ? seg_clk1   : seg_clk0;
         sd = sel ? seg_dout1  : seg_dout0;
         bz = sel ? busy1      : busy0;
         lt = sel ? seg_latch1 : seg_latch0;
         dn = sel ? done1      : done0;
         if (bz) bc++;
         if (sc != pc) tg++;
         if (sc && !pc) begin
            b = {b[62:0], sd};
            n++;
         end
         pc = sc;
         if (lt) begin
            lc++;
            if (n != 64) le++;
         end
         if (dn) begin
            da = cyc;
            break;
         end
      end
      check("done_within_budget", 64'(da >= 0), 64'd1);
   endtask

   initial begin
      // Reset with refresh asserted: everything stays low.
      rst_n = 1'b0; refresh0 = 1'b1; refresh1 = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outs_div2", {busy0, done0, seg_clk0, seg_dout0, seg_latch0, seg_clrn0}, 64'd0);
      check("reset_outs_div1", {busy1, done1, seg_clk1, seg_dout1, seg_latch1, seg_clrn1}, 64'd0);
      refresh0 = 1'b0; refresh1 = 1'b0;
      rst_n = 1'b1;
      #1;
      check("clrn_before_edge", seg_clrn0, 64'd0);
      @(negedge clk);
      check("clrn_busy_after_edge", {seg_clrn0, busy0}, 64'b10);
      acc = 0;
      repeat (5) begin
         @(negedge clk);
         acc += busy0;
      end
      check("idle_without_refresh", acc, 64'd0);

      // Single transfer, CLK_DIV=2.
      pattern = 64'hFEDC_BA98_7654_3210;
      xfer(1'b0, 1'b0, 0, bits, nb, busy_c, latch_c, latch_early, toggles, done_at);
      check("single_bits", bits, 64'hFEDC_BA98_7654_3210);
      check("single_bitcount", nb, 64'd64);
      check("single_busy_cycles", busy_c, 64'd258);
      check("single_latch_cycles", latch_c, 64'd2);
      check("single_latch_after_last_bit", latch_early, 64'd0);
      @(negedge clk);
      check("single_done_one_cycle", done0, 64'd0);

      // Queued request: three pulses collapse into one extra transfer.
      pattern = 64'h0123_4567_89AB_CDEF;
      xfer(1'b0, 1'b0, 1, bits, nb, busy_c, latch_c, latch_early, toggles, done_at);
      check("queue_first_bits", bits, 64'h0123_4567_89AB_CDEF);
      done_prev = done_at;
      pattern = 64'hFFFF_FFFF_FFFF_FF00;
      xfer(1'b0, 1'b0, 3, bits, nb, busy_c, latch_c, latch_early, toggles, done_at);
      check("queue_second_bits", bits, 64'hFFFF_FFFF_FFFF_FF00);
      check("queue_second_busy", busy_c, 64'd258);
      check("queue_min_period", done_at - done_prev, 64'd260);
      acc = 0;
      repeat (20) begin
         @(negedge clk);
         acc += busy0;
      end
      check("queue_no_third_transfer", acc, 64'd0);

      // Pattern changes every cycle after the start edge.
      pattern = 64'hA5A5_0F0F_3C3C_9669;
      xfer(1'b0, 1'b1, 0, bits, nb, busy_c, latch_c, latch_early, toggles, done_at);
      check("stable_bits", bits, 64'hA5A5_0F0F_3C3C_9669);
      check("stable_busy", busy_c, 64'd258);

      // Reset at bit 30 with a request already queued.
      @(negedge clk);
      pattern = 64'h1111_2222_3333_4444;
      refresh0 = 1'b1;
      prev_clk = 1'b0; nb = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         refresh0 = (i == 5);
         if (seg_clk0 && !prev_clk) nb++;
         prev_clk = seg_clk0;
         if (nb == 30) break;
      end
      check("midreset_reached_bit30", nb, 64'd30);
      rst_n = 1'b0;
      #1;
      check("midreset_outs", {busy0, done0, seg_clk0, seg_dout0, seg_latch0, seg_clrn0}, 64'd0);
      acc = 0;
      repeat (4) begin
         @(negedge clk);
         acc += done0;
      end
      check("midreset_no_done", acc, 64'd0);
      rst_n = 1'b1;
      acc = 0;
      repeat (6) begin
         @(negedge clk);
         acc += busy0;
      end
      check("midreset_pending_lost", acc, 64'd0);
      pattern = 64'hDEAD_BEEF_CAFE_F00D;
      xfer(1'b0, 1'b0, 0, bits, nb, busy_c, latch_c, latch_early, toggles, done_at);
      check("after_reset_bits", bits, 64'hDEAD_BEEF_CAFE_F00D);
      check("after_reset_busy", busy_c, 64'd258);

      // CLK_DIV=1 with refresh held high: back-to-back transfers.
      pattern = 64'h8000_0000_0000_0001;
      refresh1 = 1'b1;
      xfer(1'b1, 1'b0, 2, bits, nb, busy_c, latch_c, latch_early, toggles, done_at);
      check("div1_bits", bits, 64'h8000_0000_0000_0001);
      check("div1_busy", busy_c, 64'd129);
      check("div1_toggles", toggles, 64'd128);
      check("div1_latch", latch_c, 64'd1);
      done_prev = done_at;
      pattern = 64'h7E7E_7E7E_0000_FFFF;
      xfer(1'b1, 1'b0, 2, bits, nb, busy_c, latch_c, latch_early, toggles, done_at);
      check("div1_second_bits", bits, 64'h7E7E_7E7E_0000_FFFF);
      check("div1_second_busy", busy_c, 64'd129);
      check("div1_done_period", done_at - done_prev, 64'd131);
      refresh1 = 1'b0;

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/seg7_serial_driver.md
Name: seg7_serial_driver

Overview:
Sequences the 64-bit active-low segment pattern produced by the 8-digit seven-segment decoder out to the board's serial shift-register display chain. On a refresh request it captures the pattern and shifts it MSB-first on a divided serial clock. It then pulses the output latch and signals completion. Sits between the display datapath and the SEG_* board pins; one refresh request can be queued while a transfer is in progress.

Parameters:
CLK_DIV, 2, half-period of seg_clk in clk cycles; legal values are 1 or more.
WIDTH, 64, number of bits shifted per transfer (8 digits x 8 segments).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
pattern  input  WIDTH  segment pattern; bit WIDTH-1 is shifted first.
refresh  input  1  transfer request; level sampled each clk.
busy  output  1  high while a transfer is in progress.
done  output  1  one-cycle pulse when a transfer completes.
seg_clk  output  1  serial shift clock; the display samples on its rising edge.
seg_dout  output  1  serial data.
seg_latch  output  1  shift-register output-latch pulse, active-high.
seg_clrn  output  1  active-low clear for the display chain.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, seg_clk=0, seg_dout=0, seg_latch=0, seg_clrn=0; pending flag and counters cleared.
- seg_clrn goes to 1 on the first clk edge after rst_n is released, then stays 1.
- All outputs are driven directly from flops; no combinational glitches.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- Start condition, IDLE at clk edge with (refresh | pending):
  - sreg <= pattern; the pattern value at start time is used, not at request time.
  - bitcnt <= WIDTH-1; divcnt <= 0; pending <= 0; busy <= 1; go to SHIFT_LO.
- SHIFT_LO: seg_clk=0 and seg_dout=sreg[WIDTH-1] for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: seg_clk=1 for CLK_DIV cycles, seg_dout held stable. At the end of the phase:
  - sreg shifts left by 1.
  - If bitcnt==0, go to LATCH; otherwise bitcnt decrements and go to SHIFT_LO.
- LATCH: seg_clk=0, seg_latch=1 for CLK_DIV cycles, then go to DONE.
- DONE: busy=0, done=1 for exactly one cycle, seg_latch=0; next state is IDLE.
- Timing:
  - busy is high for exactly (2*WIDTH+1)*CLK_DIV cycles; 258 with the defaults.
  - done occurs in the cycle after busy falls.
  - A new transfer can start in the cycle after DONE; the minimum period is (2*WIDTH+1)*CLK_DIV+2 cycles.
- Queuing: refresh=1 in any state other than IDLE sets pending. Multiple requests during one transfer collapse into one.
  - refresh held high continuously gives back-to-back transfers.
- Changes on pattern after the start edge do not affect the transfer in progress.
- divcnt width is $clog2(CLK_DIV)+1; bitcnt width is $clog2(WIDTH).
- Reset mid-transfer aborts immediately: outputs return to their reset values, no done pulse, pending is lost.

Test Plan:
- Reset: assert rst_n=0 with refresh=1 -> all outputs 0. Release -> seg_clrn=1 one edge later, busy stays 0 until the first sampled refresh.
- Single transfer, CLK_DIV=2, pattern=64'hFEDC_BA98_7654_3210, one-cycle refresh:
  - 64 bits sampled on seg_clk rising edges equal the pattern MSB-first.
  - busy high 258 cycles; seg_latch high 2 cycles after the 64th bit; done is a single pulse.
- Queued request, CLK_DIV=2:
  - Three refresh pulses during a transfer -> exactly one extra transfer, starting the cycle after done.
  - The extra transfer shifts the pattern value present at that start (e.g. 64'hFFFF_FFFF_FFFF_FF00).
- Pattern stability: change pattern every cycle during a transfer -> the shifted data equals the value captured at start.
- Reset mid-shift, asserted at bit 30 -> all outputs drop to 0 immediately, no done pulse. After release plus one refresh, a full, correct 64-bit transfer follows.
- CLK_DIV=1, refresh held high -> seg_clk toggles every cycle, busy high 129 cycles per transfer, and done occurs every 131 cycles.
